pool_stream_engine: RTL and testbench
=====================================

Name: pool_stream_engine

Overview:
- Streaming K x K pooling unit; successor to the fixed 2x2 combinational average pool.
- Consumes one image of IMG_N x IMG_N signed pixels in row-major order, one pixel per accepted cycle.
- Emits (IMG_N/K)^2 pooled pixels, selectable average or max, with stride equal to K (non-overlapping windows).
- Sits between a convolution stage's output stream and the next layer; per-frame start/finish handshake.

Parameters:
DATA_W, 16, pixel width, signed two's complement
IMG_N, 28, input image side length in pixels (>= K)
K, 2, window side and stride (2..4)

Ports:
clk  in  1  clock; all state changes on rising edge
rst  in  1  synchronous active-high reset
start  in  1  one-cycle frame start request; honoured only in IDLE
mode  in  1  0 = average, 1 = max; sampled on accepted start
in_valid  in  1  in_pixel valid
in_pixel  in  DATA_W  signed input pixel
in_ready  out  1  high only in RUN; pixel accepted when in_valid & in_ready
out_valid  out  1  one-cycle pulse per pooled pixel
out_pixel  out  DATA_W  signed pooled result; held between pulses
busy  out  1  high in RUN and DONE
finish  out  1  one-cycle pulse in DONE

Behaviour:
- Reset (any state, including mid-frame): state = IDLE; in_ready, out_valid, out_pixel, busy, finish = 0; row/col counters and accumulators cleared. Partial frame discarded, no output.
- OUT_N = IMG_N / K (floor). Pixels with row >= OUT_N*K or col >= OUT_N*K are accepted and counted but never affect any result.
- FSM: IDLE -> RUN on start (mode latched, counters = 0). RUN -> DONE in the cycle the pixel at (IMG_N-1, IMG_N-1) is accepted. DONE -> IDLE after exactly one cycle.
- start in RUN or DONE is ignored; mode changes outside the start cycle are ignored.
- Counters: col increments per accepted pixel, wraps IMG_N-1 -> 0 and increments row. Cycles with in_valid = 0 change nothing (gaps allowed, arbitrary length).
- Accumulator bank: OUT_N entries, one per output column, width DATA_W + 2*clog2(K) signed.
  - First pixel of a window (row%K == 0 and col%K == 0) loads the entry.
  - Subsequent pixels: avg adds; max keeps signed maximum.
- Emission: when the accepted pixel is the window's last (row%K == K-1, col%K == K-1, inside the pooled region), out_valid = 1 and out_pixel updated on the next cycle.
  - Registered latency: 1 cycle after acceptance.
  - avg: (sum including current pixel) / (K*K), signed, truncated toward zero.
  - max: signed max including current pixel.
- Output order is row-major over the OUT_N x OUT_N grid.
- finish: the final pooled output and finish share the DONE cycle when the grid's last window ends on the last input pixel (IMG_N % K == 0); otherwise the final out_valid precedes finish.
- No output backpressure: downstream must accept every out_valid pulse.
- New frame: start accepted the cycle after DONE (in IDLE); the earliest pixel acceptance is the following cycle.

Test Plan:
- IMG_N=4, K=2, mode=0, pixels 0..15 continuous -> out_pixel 2, 4, 10, 12, each 1 cycle after pixels 5, 7, 13, 15; finish coincides with value 12.
- Same stream, mode=1 -> 5, 7, 13, 15.
- IMG_N=4, K=2, all pixels of window 0 = -1, -2, -3, -4, rest 0 -> avg first output -2 (-10/4 truncated toward zero); max first output -1.
- IMG_N=5, K=2, pixels 0..24, random in_valid gaps -> avg outputs 3, 5, 13, 15; row 4 and col 4 ignored; finish 1 cycle after pixel 24 is accepted; out_valid never with in_valid gaps alone.
- start pulsed mid-RUN with mode flipped -> ignored, results unchanged; rst asserted after 6 pixels -> next cycle all outputs 0, IDLE; a fresh frame then produces correct results.
- Two back-to-back frames (start in the cycle after finish) -> second frame's results correct; no accumulator carry-over.

Source files
------------

// File: rtl/pool_stream_engine.sv
// Streaming K x K pooling engine: accepts one IMG_N x IMG_N frame in row-major order and
// emits the (IMG_N/K)^2 non-overlapping window averages or maxima, one cycle after each window closes.
module pool_stream_engine #(
   parameter int DATA_W = 16,
   parameter int IMG_N  = 28,
   parameter int K      = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              mode,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_pixel,
   output logic              in_ready,
   output logic              out_valid,
   output logic [DATA_W-1:0] out_pixel,
   output logic              busy,
   output logic              finish
);

   localparam int OUT_N  = IMG_N / K;
   localparam int POOL_N = OUT_N * K;
   localparam int ACC_W  = DATA_W + 2 * $clog2(K);
   localparam int CNT_W  = $clog2(IMG_N);
   localparam int KC_W   = $clog2(K);
   localparam int OC_W   = (OUT_N > 1) ? $clog2(OUT_N) : 1;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   localparam logic [CNT_W:0]            POOL_C = (CNT_W + 1)'(POOL_N);
   localparam logic [CNT_W-1:0]          LAST_C = CNT_W'(IMG_N - 1);
   localparam logic [KC_W-1:0]           KM1_C  = KC_W'(K - 1);
   localparam logic [OC_W-1:0]           OCM_C  = OC_W'(OUT_N - 1);
   localparam logic signed [ACC_W-1:0]   KK_C   = ACC_W'(K * K);

   logic [1:0]              state_q, state_d;
   logic                    mode_q, mode_d;
   logic [CNT_W-1:0]        row_q, row_d, col_q, col_d;
   logic [KC_W-1:0]         kr_q, kr_d, kc_q, kc_d;
   logic [OC_W-1:0]         oc_q, oc_d;
   logic signed [ACC_W-1:0] acc_q [OUT_N];
   logic signed [ACC_W-1:0] acc_d [OUT_N];
   logic                    out_valid_q, out_valid_d;
   logic [DATA_W-1:0]       out_pixel_q, out_pixel_d;

   logic                    accept, in_pool, last_col, win_first, win_last;
   logic signed [ACC_W-1:0] pix_ext, sum_w, max_w, avg_w;

   assign accept    = in_valid && (state_q == S_RUN);
   assign in_pool   = ({1'b0, row_q} < POOL_C) && ({1'b0, col_q} < POOL_C);
   assign last_col  = (col_q == LAST_C);
   assign win_first = (kr_q == '0) && (kc_q == '0);
   assign win_last  = (kr_q == KM1_C) && (kc_q == KM1_C) && in_pool;

   assign pix_ext = {{(ACC_W - DATA_W){in_pixel[DATA_W-1]}}, in_pixel};
   assign sum_w   = acc_q[oc_q] + pix_ext;
   assign max_w   = (pix_ext > acc_q[oc_q]) ? pix_ext : acc_q[oc_q];
   // Signed division truncates toward zero, which is the rounding the average needs.
   assign avg_w   = sum_w / KK_C;

   always_comb begin
      // NOTE: every next-state signal gets a default first so no path leaves it unassigned (no latches).
      state_d     = state_q;
      mode_d      = mode_q;
      row_d       = row_q;
      col_d       = col_q;
      kr_d        = kr_q;
      kc_d        = kc_q;
      oc_d        = oc_q;
      acc_d       = acc_q;
      out_valid_d = 1'b0;
      out_pixel_d = out_pixel_q;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = S_RUN;
               mode_d  = mode;
               row_d   = '0;
               col_d   = '0;
               kr_d    = '0;
               kc_d    = '0;
               oc_d    = '0;
            end
         end
         S_RUN: begin
            if (accept) begin
               if (in_pool) begin
                  if (win_first)   acc_d[oc_q] = pix_ext;
                  else if (mode_q) acc_d[oc_q] = max_w;
                  else             acc_d[oc_q] = sum_w;
               end
               if (win_last) begin
                  out_valid_d = 1'b1;
                  out_pixel_d = mode_q ? max_w[DATA_W-1:0] : avg_w[DATA_W-1:0];
               end
               if (last_col) begin
                  col_d = '0;
                  kc_d  = '0;
                  oc_d  = '0;
                  row_d = row_q + 1'b1;
                  kr_d  = (kr_q == KM1_C) ? '0 : kr_q + 1'b1;
                  if (row_q == LAST_C) state_d = S_DONE;
               end else begin
                  col_d = col_q + 1'b1;
                  if (kc_q == KM1_C) begin
                     kc_d = '0;
                     // Saturate on the last window column; columns past the pooled region never write.
                     if (oc_q != OCM_C) oc_d = oc_q + 1'b1;
                  end else begin
                     kc_d = kc_q + 1'b1;
                  end
               end
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         mode_q      <= 1'b0;
         row_q       <= '0;
         col_q       <= '0;
         kr_q        <= '0;
         kc_q        <= '0;
         oc_q        <= '0;
         // NOTE: the accumulator bank is only OUT_N registers, so it is cleared with the rest of the state.
         acc_q       <= '{default: '0};
         out_valid_q <= 1'b0;
         out_pixel_q <= '0;
      end else begin
         state_q     <= state_d;
         mode_q      <= mode_d;
         row_q       <= row_d;
         col_q       <= col_d;
         kr_q        <= kr_d;
         kc_q        <= kc_d;
         oc_q        <= oc_d;
         acc_q       <= acc_d;
         out_valid_q <= out_valid_d;
         out_pixel_q <= out_pixel_d;
      end
   end

   assign in_ready  = (state_q == S_RUN);
   assign busy      = (state_q != S_IDLE);
   assign finish    = (state_q == S_DONE);
   assign out_valid = out_valid_q;
   assign out_pixel = out_pixel_q;

endmodule

// File: tb/tb_pool_stream_engine.sv
// Bench for pool_stream_engine: two instances (4x4 and 5x5 frames, K=2) checked every cycle
// against a frame-level window model plus literal expectations for the hand-worked cases.
module tb_pool_stream_engine;

   localparam int KP = 2;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic        rst_s [2];
   logic        start_s [2];
   logic        mode_s [2];
   logic        in_valid_s [2];
   logic [15:0] in_pix_s [2];
   logic        in_ready_w [2];
   logic        out_valid_w [2];
   logic [15:0] out_pix_w [2];
   logic        busy_w [2];
   logic        finish_w [2];

   int frame_pix [2][25];
   int exp_val [2][$];
   int ov_cyc [2][$];
   int got [2][$];
   int fin_cyc [2] = '{-1, -1};
   bit chk_en = 1'b0;

   int n_tests = 0;
   int n_fail  = 0;

   pool_stream_engine #(.DATA_W(16), .IMG_N(4), .K(KP)) u_dut4 (
      .clk(clk), .rst(rst_s[0]), .start(start_s[0]), .mode(mode_s[0]),
      .in_valid(in_valid_s[0]), .in_pixel(in_pix_s[0]), .in_ready(in_ready_w[0]),
      .out_valid(out_valid_w[0]), .out_pixel(out_pix_w[0]), .busy(busy_w[0]),
      .finish(finish_w[0])
   );

   pool_stream_engine #(.DATA_W(16), .IMG_N(5), .K(KP)) u_dut5 (
      .clk(clk), .rst(rst_s[1]), .start(start_s[1]), .mode(mode_s[1]),
      .in_valid(in_valid_s[1]), .in_pixel(in_pix_s[1]), .in_ready(in_ready_w[1]),
      .out_valid(out_valid_w[1]), .out_pixel(out_pix_w[1]), .busy(busy_w[1]),
      .finish(finish_w[1])
   );

   task automatic check(input string name, input int actual, input int expected);
      n_tests++;
      if (actual !== expected) begin
         n_fail++;
         $display("FAIL %s (cycle %0d): got %0d, expected %0d", name, cyc, actual, expected);
      end
   endtask

   function automatic int side(input int u);
      return (u == 0) ? 4 : 5;
   endfunction

   // Reference: pool every complete KP x KP window of the stored frame, row-major.
   function automatic void build_expected(input int u, input bit m);
      int n, on, s, mx, p;
      n  = side(u);
      on = n / KP;
      for (int orow = 0; orow < on; orow++)
         for (int ocol = 0; ocol < on; ocol++) begin
            s  = 0;
            mx = -(1 << 30);
            for (int dr = 0; dr < KP; dr++)
               for (int dc = 0; dc < KP; dc++) begin
                  p  = frame_pix[u][(orow * KP + dr) * n + ocol * KP + dc];
                  s += p;
                  if (p > mx) mx = p;
               end
            exp_val[u].push_back(m ? mx : s / (KP * KP));
         end
   endfunction

   always @(negedge clk) begin
      bit exp_ov, exp_fin;
      int ev;
      if (chk_en) begin
         for (int u = 0; u < 2; u++) begin
            exp_ov  = (ov_cyc[u].size() != 0) && (ov_cyc[u][0] == cyc);
            exp_fin = (fin_cyc[u] == cyc);
            ev      = 0;
            if (exp_ov) begin
               void'(ov_cyc[u].pop_front());
               if (exp_val[u].size() != 0) ev = exp_val[u].pop_front();
            end
            check($sformatf("out_valid[u%0d]", u), int'(out_valid_w[u]), int'(exp_ov));
            check($sformatf("finish[u%0d]", u), int'(finish_w[u]), int'(exp_fin));
            if (exp_ov && out_valid_w[u])
               check($sformatf("out_pixel[u%0d]", u), int'($signed(out_pix_w[u])), ev);
            if (out_valid_w[u]) got[u].push_back(int'($signed(out_pix_w[u])));
         end
      end
   end

   task automatic fill(input int u, input int pat);
      for (int i = 0; i < 25; i++) begin
         case (pat)
            0:       frame_pix[u][i] = i;
            1:       frame_pix[u][i] = int'($urandom_range(0, 65535)) - 32768;
            default: frame_pix[u][i] = 0;
         endcase
      end
      if (pat == 2) begin
         frame_pix[u][0] = -1;
         frame_pix[u][1] = -2;
         frame_pix[u][side(u)]     = -3;
         frame_pix[u][side(u) + 1] = -4;
      end
   endtask

   task automatic check_outputs_zero(input int u, input string tag);
      check({tag, "_in_ready"}, int'(in_ready_w[u]), 0);
      check({tag, "_out_valid"}, int'(out_valid_w[u]), 0);
      check({tag, "_out_pixel"}, int'(out_pix_w[u]), 0);
      check({tag, "_busy"}, int'(busy_w[u]), 0);
      check({tag, "_finish"}, int'(finish_w[u]), 0);
   endtask

   // Called in IDLE at a drive point; returns one cycle after DONE (IDLE again),
   // so consecutive calls give back-to-back frames.
   task automatic run_frame(input int u, input bit m, input bit gaps, input bit glitch,
                            input int stop_after);
      int n, on, r, c, g;
      logic [15:0] pv;
      n  = side(u);
      on = n / KP;
      exp_val[u].delete();
      got[u].delete();
      build_expected(u, m);
      check("idle_in_ready", int'(in_ready_w[u]), 0);
      check("idle_busy", int'(busy_w[u]), 0);
      start_s[u] = 1'b1;
      mode_s[u]  = m;
      @(posedge clk); #1;
      start_s[u] = 1'b0;
      mode_s[u]  = ~m;
      check("run_busy", int'(busy_w[u]), 1);
      for (int i = 0; i < n * n; i++) begin
         if (stop_after >= 0 && i == stop_after) break;
         g = gaps ? int'($urandom_range(0, 2)) : 0;
         if (glitch && i == 7) g = g + 1;
         for (int k = 0; k < g; k++) begin
            in_valid_s[u] = 1'b0;
            in_pix_s[u]   = 16'($urandom);
            if (glitch && i == 7 && k == 0) start_s[u] = 1'b1;
            @(posedge clk); #1;
            start_s[u] = 1'b0;
         end
         check("in_ready", int'(in_ready_w[u]), 1);
         pv            = 16'(frame_pix[u][i]);
         in_valid_s[u] = 1'b1;
         in_pix_s[u]   = pv;
         r = i / n;
         c = i % n;
         if (r < on * KP && c < on * KP && r % KP == KP - 1 && c % KP == KP - 1)
            ov_cyc[u].push_back(cyc + 1);
         if (i == n * n - 1) fin_cyc[u] = cyc + 1;
         @(posedge clk); #1;
      end
      in_valid_s[u] = 1'b0;
      if (stop_after >= 0) begin
         rst_s[u] = 1'b1;
         @(posedge clk); #1;
         exp_val[u].delete();
         ov_cyc[u].delete();
         fin_cyc[u] = -1;
         check_outputs_zero(u, "midreset");
         rst_s[u] = 1'b0;
         return;
      end
      check("done_busy", int'(busy_w[u]), 1);
      check("done_in_ready", int'(in_ready_w[u]), 0);
      @(posedge clk); #1;
      fin_cyc[u] = -1;
      check("after_done_busy", int'(busy_w[u]), 0);
      check("leftover_outputs", exp_val[u].size(), 0);
   endtask

   task automatic check_got4(input int u, input string tag, input int a, input int b,
                             input int c, input int d);
      check({tag, "_count"}, got[u].size(), 4);
      if (got[u].size() == 4) begin
         check({tag, "_0"}, got[u][0], a);
         check({tag, "_1"}, got[u][1], b);
         check({tag, "_2"}, got[u][2], c);
         check({tag, "_3"}, got[u][3], d);
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      for (int u = 0; u < 2; u++) begin
         rst_s[u]      = 1'b1;
         start_s[u]    = 1'b0;
         mode_s[u]     = 1'b0;
         in_valid_s[u] = 1'b0;
         in_pix_s[u]   = '0;
      end
      repeat (3) @(posedge clk);
      #1;
      check_outputs_zero(0, "reset4");
      check_outputs_zero(1, "reset5");
      rst_s[0] = 1'b0;
      rst_s[1] = 1'b0;
      chk_en   = 1'b1;
      @(posedge clk); #1;

      // 4x4 ramp, average then max, continuous input.
      fill(0, 0);
      run_frame(0, 1'b0, 1'b0, 1'b0, -1);
      check_got4(0, "ramp_avg", 2, 4, 10, 12);
      run_frame(0, 1'b1, 1'b0, 1'b0, -1);
      check_got4(0, "ramp_max", 5, 7, 13, 15);

      // Negative first window: truncation toward zero and signed max.
      fill(0, 2);
      run_frame(0, 1'b0, 1'b0, 1'b0, -1);
      check_got4(0, "neg_avg", -2, 0, 0, 0);
      run_frame(0, 1'b1, 1'b0, 1'b0, -1);
      check_got4(0, "neg_max", -1, 0, 0, 0);

      // Random data with gaps and a start/mode glitch mid-frame.
      fill(0, 1);
      run_frame(0, 1'b0, 1'b1, 1'b1, -1);
      fill(0, 1);
      run_frame(0, 1'b1, 1'b1, 1'b1, -1);

      // Reset after six pixels, then a clean frame.
      fill(0, 1);
      run_frame(0, 1'b1, 1'b0, 1'b0, 6);
      @(posedge clk); #1;
      fill(0, 0);
      run_frame(0, 1'b0, 1'b0, 1'b0, -1);
      check_got4(0, "post_reset_avg", 2, 4, 10, 12);

      // Back-to-back random frames.
      fill(0, 1);
      run_frame(0, 1'b1, 1'b0, 1'b0, -1);
      fill(0, 1);
      run_frame(0, 1'b0, 1'b0, 1'b0, -1);

      // 5x5 frames: last row and column are ignored.
      fill(1, 0);
      run_frame(1, 1'b0, 1'b1, 1'b0, -1);
      check_got4(1, "img5_avg", 3, 5, 13, 15);
      fill(1, 1);
      run_frame(1, 1'b1, 1'b1, 1'b1, -1);
      fill(1, 1);
      run_frame(1, 1'b0, 1'b1, 1'b0, -1);

      for (int t = 0; t < 8; t++) begin
         int u;
         u = t % 2;
         fill(u, 1);
         run_frame(u, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0, -1);
      end

      repeat (3) @(posedge clk);
      #1;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
